// File: rtl/clksel_sequencer_pkg.sv
// Shared types and defaults for the CPU clock-switch sequencer.
// States are Gray-coded so that bit 0 is hsclk_sel and bit0^bit1 is busy.
package clksel_sequencer_pkg;

  typedef enum logic [1:0] {
    S_LS    = 2'b00,
    S_TO_HS = 2'b01,
    S_HS    = 2'b11,
    S_TO_LS = 2'b10
  } state_e;

  localparam int DWELL_DEF   = 16;
  localparam int TIMEOUT_DEF = 255;
  localparam int CNT_W_DEF   = 8;

  typedef struct packed {
    logic div_sel;
    logic delay_sel;
  } clk_cfg_t;

  function automatic logic sel_of(state_e s);
    return (s == S_TO_HS) || (s == S_HS);
  endfunction

  function automatic logic busy_of(state_e s);
    return (s == S_TO_HS) || (s == S_TO_LS);
  endfunction

endpackage

// File: rtl/clksel_sequencer_if.sv
// Sequencer <-> clock-switch connection: select/config controls out, selected feedback back.
interface clksel_sequencer_if;
  logic hsclk_sel;
  logic cpuclk_div_sel;
  logic delay_sel;
  logic hsclk_selected;
  logic lsclk_selected;

  modport master (
    output hsclk_sel, cpuclk_div_sel, delay_sel,
    input  hsclk_selected, lsclk_selected
  );

  modport slave (
    input  hsclk_sel, cpuclk_div_sel, delay_sel,
    output hsclk_selected, lsclk_selected
  );
endinterface

// File: rtl/clksel_sequencer_sync2ff.sv
// Two-flop synchroniser for the asynchronous clock-switch feedback.
module clksel_sequencer_sync2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic hsclk_in,
  input  logic rst_b,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge hsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/clksel_sequencer.sv
// CPU clock-switch sequencer: dwell hysteresis, urgent-slow bypass, handshake
// timeout with sticky error, and divider/delay updates applied only while settled slow.
module clksel_sequencer
  import clksel_sequencer_pkg::*;
#(
  parameter int   DWELL_CYCLES   = DWELL_DEF,
  parameter int   TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter int   CNT_W          = CNT_W_DEF,
  parameter logic DIV_SEL_RST    = 1'b0,
  parameter logic DELAY_SEL_RST  = 1'b0
) (
  input  logic                      hsclk_in,
  input  logic                      rst_b,
  input  logic                      hs_req,
  input  logic                      ls_urgent,
  input  logic                      cfg_we,
  input  logic                      cfg_div_sel,
  input  logic                      cfg_delay_sel,
  input  logic                      err_clr,
  clksel_sequencer_if.master        sw,
  output logic                      busy,
  output logic                      cfg_pending,
  output logic                      switch_err
);

  localparam logic [CNT_W-1:0] DWELL_C = CNT_W'(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] TO_C    = CNT_W'(TIMEOUT_CYCLES);

  state_e           state, nxt;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic             hs_s, ls_s, hs_ok, ls_ok;
  logic             dwell_done, cnt_to, tmo, ls_idle;
  logic             hsclk_sel_q;
  clk_cfg_t         cfg_q, shadow;

  // Feedback idles as "slow selected" so a fresh reset is immediately settled.
  clksel_sequencer_sync2ff #(.RST_VAL(1'b0)) u_sync_hs (
    .hsclk_in (hsclk_in),
    .rst_b    (rst_b),
    .d        (sw.hsclk_selected),
    .q        (hs_s)
  );

  clksel_sequencer_sync2ff #(.RST_VAL(1'b1)) u_sync_ls (
    .hsclk_in (hsclk_in),
    .rst_b    (rst_b),
    .d        (sw.lsclk_selected),
    .q        (ls_s)
  );

  assign hs_ok      = hs_s & ~ls_s;
  assign ls_ok      = ls_s & ~hs_s;
  assign dwell_done = (cnt >= DWELL_C);
  assign cnt_to     = (cnt == TO_C);
  assign cnt_inc    = (cnt == '1) ? cnt : cnt + 1'b1;
  assign ls_idle    = (state == S_LS) && ls_ok;

  always_comb begin
    nxt = state;
    tmo = 1'b0;
    case (state)
      S_LS: begin
        if (hs_req && !ls_urgent && dwell_done && !cfg_pending && ls_ok) nxt = S_TO_HS;
      end
      S_TO_HS: begin
        if (ls_urgent)   nxt = S_TO_LS;
        else if (hs_ok)  nxt = S_HS;
        else if (cnt_to) begin
          nxt = S_TO_LS;
          tmo = 1'b1;
        end
      end
      S_HS: begin
        if (ls_urgent)                                    nxt = S_TO_LS;
        else if ((!hs_req || cfg_pending) && dwell_done)  nxt = S_TO_LS;
      end
      S_TO_LS: begin
        // A stuck return keeps hsclk_sel low; only the counter restarts.
        if (ls_ok)       nxt = S_LS;
        else if (cnt_to) tmo = 1'b1;
      end
      default: nxt = S_LS;
    endcase
  end

  always_ff @(posedge hsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      state       <= S_LS;
      hsclk_sel_q <= 1'b0;
      busy        <= 1'b0;
      cnt         <= '0;
      switch_err  <= 1'b0;
    end else begin
      state       <= nxt;
      hsclk_sel_q <= sel_of(nxt);
      busy        <= busy_of(nxt);
      cnt         <= ((nxt != state) || tmo) ? '0 : cnt_inc;
      if (tmo)          switch_err <= 1'b1;
      else if (err_clr) switch_err <= 1'b0;
    end
  end

  // Divider/delay only move while the CPU sits on a confirmed slow clock.
  always_ff @(posedge hsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      cfg_q       <= '{div_sel: DIV_SEL_RST, delay_sel: DELAY_SEL_RST};
      shadow      <= '{div_sel: DIV_SEL_RST, delay_sel: DELAY_SEL_RST};
      cfg_pending <= 1'b0;
    end else if (cfg_we) begin
      shadow <= '{div_sel: cfg_div_sel, delay_sel: cfg_delay_sel};
      if (ls_idle) begin
        cfg_q       <= '{div_sel: cfg_div_sel, delay_sel: cfg_delay_sel};
        cfg_pending <= 1'b0;
      end else begin
        cfg_pending <= 1'b1;
      end
    end else if (cfg_pending && ls_idle) begin
      cfg_q       <= shadow;
      cfg_pending <= 1'b0;
    end
  end

  assign sw.hsclk_sel      = hsclk_sel_q;
  assign sw.cpuclk_div_sel = cfg_q.div_sel;
  assign sw.delay_sel      = cfg_q.delay_sel;

endmodule

// File: tb/tb_clksel_sequencer.sv
// Bench for clksel_sequencer: config vector table, then switch / urgent / timeout / reset sequences
// against a clock-switch model that answers hsclk_sel after 4 cycles.
module tb_clksel_sequencer;

  logic hsclk_in = 1'b0;
  logic rst_b = 1'b0;
  logic hs_req = 1'b0, ls_urgent = 1'b0, cfg_we = 1'b0;
  logic cfg_div_sel = 1'b0, cfg_delay_sel = 1'b0, err_clr = 1'b0;
  logic busy, cfg_pending, switch_err;
  logic [3:0] fb_pipe = 4'b0;
  logic fb_stuck = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic we, div, dly, clr;
    logic [5:0] exp;   // {hsclk_sel, div, delay, busy, pending, err}
  } vec_t;

  vec_t tbl[7];
  logic [5:0] exp_q[$];
  logic [1:0] cfg_exp_q[$];
  logic [5:0] mon_e;
  logic [5:0] o;

  clksel_sequencer_if bus();

  clksel_sequencer dut (
    .hsclk_in      (hsclk_in),
    .rst_b         (rst_b),
    .hs_req        (hs_req),
    .ls_urgent     (ls_urgent),
    .cfg_we        (cfg_we),
    .cfg_div_sel   (cfg_div_sel),
    .cfg_delay_sel (cfg_delay_sel),
    .err_clr       (err_clr),
    .sw            (bus),
    .busy          (busy),
    .cfg_pending   (cfg_pending),
    .switch_err    (switch_err)
  );

  always #5 hsclk_in = ~hsclk_in;

  // Clock-switch model: follows hsclk_sel 4 cycles late; when stuck, hs never confirms.
  always @(posedge hsclk_in) fb_pipe <= {fb_pipe[2:0], bus.hsclk_sel};
  assign bus.hsclk_selected = fb_stuck ? 1'b0 : fb_pipe[3];
  assign bus.lsclk_selected = ~fb_pipe[3];

  function automatic logic [5:0] outs();
    return {bus.hsclk_sel, bus.cpuclk_div_sel, bus.delay_sel, busy, cfg_pending, switch_err};
  endfunction

  task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {5'b0, act}, {5'b0, exp});
  endtask

  task automatic tick();
    @(posedge hsclk_in);
    #1;
  endtask

  // Bit index into outs(): 5 sel, 4 div, 3 delay, 2 busy, 1 pending, 0 err.
  task automatic wait_bit(input string nm, input int idx, input logic v, input int maxc);
    int n;
    logic [5:0] w;
    n = 0;
    w = outs();
    while (w[idx] !== v && n < maxc) begin
      tick();
      n++;
      w = outs();
    end
    chk1(nm, w[idx], v);
  endtask

  task automatic cfg_apply_chk(input string nm);
    logic [5:0] w;
    logic [1:0] e;
    w = outs();
    e = cfg_exp_q[$];
    cfg_exp_q.delete();
    chk(nm, {4'b0, w[4:3]}, {4'b0, e});
  endtask

  // Scoreboard drain: expectations pushed at the driving edge are compared half a cycle later.
  always @(negedge hsclk_in) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("tbl", outs(), mon_e);
    end
  end

  initial begin
    tbl[0] = '{we:1'b0, div:1'b0, dly:1'b0, clr:1'b0, exp:6'b0_0_0_000};
    tbl[1] = '{we:1'b1, div:1'b1, dly:1'b0, clr:1'b0, exp:6'b0_1_0_000};
    tbl[2] = '{we:1'b0, div:1'b0, dly:1'b1, clr:1'b0, exp:6'b0_1_0_000};
    tbl[3] = '{we:1'b1, div:1'b0, dly:1'b1, clr:1'b0, exp:6'b0_0_1_000};
    tbl[4] = '{we:1'b1, div:1'b1, dly:1'b1, clr:1'b0, exp:6'b0_1_1_000};
    tbl[5] = '{we:1'b0, div:1'b0, dly:1'b0, clr:1'b1, exp:6'b0_1_1_000};
    tbl[6] = '{we:1'b1, div:1'b0, dly:1'b0, clr:1'b0, exp:6'b0_0_0_000};

    repeat (2) @(posedge hsclk_in);
    #1;
    chk("rst_state", outs(), 6'b0);
    @(negedge hsclk_in);
    rst_b = 1'b1;

    // Settled slow with hs_req low: config writes land the next cycle.
    for (int i = 0; i < 7; i++) begin
      cfg_we = tbl[i].we; cfg_div_sel = tbl[i].div;
      cfg_delay_sel = tbl[i].dly; err_clr = tbl[i].clr;
      @(posedge hsclk_in);
      exp_q.push_back(tbl[i].exp);
      @(negedge hsclk_in);
    end
    cfg_we = 1'b0; err_clr = 1'b0;

    // Fast switch from reset: dwell 16, rise on edge 17, confirm on edge 24.
    rst_b = 1'b0;
    hs_req = 1'b1;
    @(negedge hsclk_in);
    rst_b = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      tick();
      o = outs();
      if (c == 16) begin chk1("dwell_hold", o[5], 1'b0); chk1("dwell_busy", o[2], 1'b0); end
      if (c == 17) begin chk1("sel_rise", o[5], 1'b1); chk1("busy_to_hs", o[2], 1'b1); end
      if (c == 23) chk1("busy_wait", o[2], 1'b1);
      if (c == 24) begin chk1("hs_entry_busy", o[2], 1'b0); chk1("hs_entry_sel", o[5], 1'b1); end
    end

    // Urgent slow at dwell count 3, then a full re-dwell before going fast again.
    repeat (3) tick();
    ls_urgent = 1'b1;
    tick();
    o = outs();
    chk1("urgent_sel", o[5], 1'b0);
    chk1("urgent_busy", o[2], 1'b1);
    ls_urgent = 1'b0;
    repeat (6) tick();
    chk1("to_ls_wait", busy, 1'b1);
    tick();
    chk1("ls_entry", busy, 1'b0);
    repeat (16) tick();
    chk1("redwell_hold", bus.hsclk_sel, 1'b0);
    tick();
    chk1("redwell_rise", bus.hsclk_sel, 1'b1);

    // Config write in S_HS forces a trip to slow even with hs_req held.
    wait_bit("hs_again", 2, 1'b0, 20);
    cfg_we = 1'b1; cfg_div_sel = 1'b1; cfg_delay_sel = 1'b1;
    cfg_exp_q.push_back(2'b11);
    tick();
    cfg_we = 1'b0;
    o = outs();
    chk1("pend_set", o[1], 1'b1);
    chk("cfg_held", {4'b0, o[4:3]}, 6'b0);
    repeat (15) tick();
    chk1("pend_hold_hs", bus.hsclk_sel, 1'b1);
    tick();
    chk1("pend_exit", bus.hsclk_sel, 1'b0);
    repeat (6) tick();
    chk1("apply_busy", busy, 1'b1);
    tick();
    o = outs();
    chk1("apply_ls_entry", o[2], 1'b0);
    chk1("apply_wait_pend", o[1], 1'b1);
    chk1("apply_wait_div", o[4], 1'b0);
    tick();
    chk1("apply_pend_clr", cfg_pending, 1'b0);
    cfg_apply_chk("cfg_apply");
    repeat (15) tick();
    chk1("reenter_hold", bus.hsclk_sel, 1'b0);
    tick();
    chk1("reenter_hs", bus.hsclk_sel, 1'b1);

    // Two writes while pending: the last one is applied.
    wait_bit("hs_again2", 2, 1'b0, 20);
    cfg_we = 1'b1; cfg_div_sel = 1'b1; cfg_delay_sel = 1'b1;
    cfg_exp_q.push_back(2'b11);
    tick();
    cfg_div_sel = 1'b0; cfg_delay_sel = 1'b1;
    cfg_exp_q.push_back(2'b01);
    tick();
    cfg_we = 1'b0;
    o = outs();
    chk1("pend_set2", o[1], 1'b1);
    chk("cfg_held2", {4'b0, o[4:3]}, 6'b000011);
    wait_bit("pend_clr2", 1, 1'b0, 60);
    cfg_apply_chk("cfg_last_wins");

    // Feedback never confirms fast: timeout after 256 edges in S_TO_HS.
    fb_stuck = 1'b1;
    wait_bit("to_hs_stuck", 5, 1'b1, 30);
    repeat (255) tick();
    chk1("pre_timeout_err", switch_err, 1'b0);
    chk1("pre_timeout_sel", bus.hsclk_sel, 1'b1);
    tick();
    chk1("timeout_err", switch_err, 1'b1);
    chk1("timeout_sel", bus.hsclk_sel, 1'b0);
    wait_bit("ls_after_to", 2, 1'b0, 20);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk1("err_clr", switch_err, 1'b0);
    wait_bit("to_hs_stuck2", 5, 1'b1, 30);
    repeat (255) tick();
    chk1("pre_timeout2", switch_err, 1'b0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk1("clr_vs_set", switch_err, 1'b1);

    // Asynchronous reset in the middle of S_TO_HS.
    wait_bit("to_hs_stuck3", 5, 1'b1, 40);
    cfg_we = 1'b1; cfg_div_sel = 1'b1; cfg_delay_sel = 1'b0;
    tick();
    cfg_we = 1'b0;
    chk("pre_rst", outs(), 6'b1_0_1_111);
    #3;
    rst_b = 1'b0;
    #1;
    chk("async_rst", outs(), 6'b0);
    #20;
    rst_b = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
